button_event_ctrl: RTL and testbench

Converts the per-button debounced levels from the debounce stage into a stream of discrete key events: PRESS, RELEASE, LONG and REPEAT. One timing FSM runs per button. A round-robin arbiter then shares a single registered valid/ready event output among all buttons. The block sits between the debounce bank and the UI/command logic, so downstream consumers never see raw levels.

---
 rtl/button_event_ctrl_pkg.sv | 19 +
 rtl/button_event_ctrl_fsm.sv | 107 ++++++++++
 rtl/button_event_ctrl.sv | 119 +++++++++++
 tb/tb_button_event_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/button_event_ctrl_pkg.sv
// Shared constants for the button event controller: event codes,
// per-button FSM state encoding and the pending-entry record.
package button_event_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_RELEASE = 2'd1;
  localparam logic [1:0] EVT_LONG    = 2'd2;
  localparam logic [1:0] EVT_REPEAT  = 2'd3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DOWN = 2'd1;
  localparam logic [1:0] HELD = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } pend_t;

endpackage

// File: rtl/button_event_ctrl_fsm.sv
// One button: registered active level, PRESS/LONG/REPEAT/RELEASE timing FSM
// and a single-entry pending slot that the top-level arbiter drains via grant.
module button_event_fsm
  import button_event_pkg::*;
#(
  parameter int LONG_TIMEOUT  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  parameter int CNT_W         = 25
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  act,
  input  logic  grant,
  output pend_t pend,
  output logic  drop
);

  logic             act_reg;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  pend_t            pend_reg, pend_next;
  logic             emit;
  logic [1:0]       emit_code;
  logic             pend_load;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    emit       = 1'b0;
    emit_code  = EVT_PRESS;
    case (state_reg)
      IDLE: begin
        if (act_reg) begin
          emit       = 1'b1;
          emit_code  = EVT_PRESS;
          state_next = DOWN;
          cnt_next   = '0;
        end
      end
      DOWN: begin
        // Release is checked first so it beats LONG on the threshold cycle
        if (!act_reg) begin
          emit       = 1'b1;
          emit_code  = EVT_RELEASE;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(LONG_TIMEOUT - 1)) begin
          emit       = 1'b1;
          emit_code  = EVT_LONG;
          state_next = HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (!act_reg) begin
          emit       = 1'b1;
          emit_code  = EVT_RELEASE;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(REPEAT_PERIOD - 1)) begin
          emit      = 1'b1;
          emit_code = EVT_REPEAT;
          cnt_next  = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A full slot can still accept a new event when it is drained on this edge
  assign pend_load = emit && (!pend_reg.valid || grant);
  assign drop      = emit && !pend_load;

  always_comb begin
    pend_next = pend_reg;
    if (pend_load) begin
      pend_next.valid = 1'b1;
      pend_next.code  = emit_code;
    end else if (grant) begin
      pend_next.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_reg   <= 1'b0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pend_reg  <= '0;
    end else begin
      act_reg   <= act;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
    end
  end

  assign pend = pend_reg;

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: per-button event FSMs feeding a round-robin
// arbiter and a registered valid/ready event output with a sticky drop flag.
module button_event_ctrl
  import button_event_pkg::*;
#(
  parameter int    WIDTH         = 6,
  parameter string POLARITY      = "LOW",
  parameter int    LONG_TIMEOUT  = 25000000,
  parameter int    REPEAT_PERIOD = 5000000,
  parameter int    CNT_W         = 25,
  parameter int    IDX_W         = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_in,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_btn,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] btn_active,
  output logic             ovf
);

  pend_t [WIDTH-1:0] pend;
  logic  [WIDTH-1:0] pend_valid;
  logic  [WIDTH-1:0] grant_vec;
  logic  [WIDTH-1:0] drop_vec;

  logic             evt_valid_reg;
  logic [IDX_W-1:0] evt_btn_reg;
  logic [1:0]       evt_code_reg;
  logic [IDX_W-1:0] rr_reg, rr_next;
  logic             ovf_reg;

  logic             load_en;
  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;
  logic [1:0]       gnt_code;
  int               scan_idx;

  generate
    if (POLARITY == "HIGH") begin : g_pol_high
      assign btn_active = btn_in;
    end else begin : g_pol_low
      assign btn_active = ~btn_in;
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_btn
      button_event_fsm #(
        .LONG_TIMEOUT  (LONG_TIMEOUT),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
      ) u_fsm (
        .clk     (clk),
        .reset_n (reset_n),
        .act     (btn_active[gi]),
        .grant   (grant_vec[gi]),
        .pend    (pend[gi]),
        .drop    (drop_vec[gi])
      );
      assign pend_valid[gi] = pend[gi].valid;
    end
  endgenerate

  // First pending button at or after rr, wrapping past WIDTH-1
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_code  = EVT_PRESS;
    scan_idx  = 0;
    for (int k = 0; k < WIDTH; k++) begin
      scan_idx = (int'(rr_reg) + k) % WIDTH;
      if (!gnt_found && pend_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(scan_idx);
        gnt_code  = pend[scan_idx].code;
      end
    end
  end

  assign load_en   = !evt_valid_reg || evt_ready;
  assign grant_vec = (load_en && gnt_found) ? (WIDTH'(1) << gnt_idx) : '0;
  assign rr_next   = (gnt_idx == IDX_W'(WIDTH - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid_reg <= 1'b0;
      evt_btn_reg   <= '0;
      evt_code_reg  <= '0;
      rr_reg        <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      if (load_en) begin
        evt_valid_reg <= gnt_found;
        if (gnt_found) begin
          evt_btn_reg  <= gnt_idx;
          evt_code_reg <= gnt_code;
          rr_reg       <= rr_next;
        end
      end
      // A drop in the same cycle as clr_ovf keeps the flag set
      if (|drop_vec) begin
        ovf_reg <= 1'b1;
      end else if (clr_ovf) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  assign evt_valid = evt_valid_reg;
  assign evt_btn   = evt_btn_reg;
  assign evt_code  = evt_code_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed, table-driven bench for button_event_ctrl with short timeouts
// (LONG_TIMEOUT=8, REPEAT_PERIOD=4, active-low buttons).
module tb_button_event_ctrl;

  localparam int WIDTH = 6;
  localparam int IDX_W = 3;
  localparam logic [1:0] C_PRESS   = 2'd0;
  localparam logic [1:0] C_RELEASE = 2'd1;
  localparam logic [1:0] C_LONG    = 2'd2;
  localparam logic [1:0] C_REPEAT  = 2'd3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] btn_in;
  logic             evt_ready;
  logic             clr_ovf;
  logic             evt_valid;
  logic [IDX_W-1:0] evt_btn;
  logic [1:0]       evt_code;
  logic [WIDTH-1:0] btn_active;
  logic             ovf;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .WIDTH         (WIDTH),
    .POLARITY      ("LOW"),
    .LONG_TIMEOUT  (8),
    .REPEAT_PERIOD (4),
    .CNT_W         (4),
    .IDX_W         (IDX_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_in     (btn_in),
    .evt_ready  (evt_ready),
    .clr_ovf    (clr_ovf),
    .evt_valid  (evt_valid),
    .evt_btn    (evt_btn),
    .evt_code   (evt_code),
    .btn_active (btn_active),
    .ovf        (ovf)
  );

  // One row = inputs held for one clock, outputs expected after that edge
  typedef struct {
    logic [WIDTH-1:0] act;
    logic             rdy;
    logic             clr;
    logic             vld;
    logic [IDX_W-1:0] btn;
    logic [1:0]       code;
    logic             ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input string what, input int row,
                       input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s/%s row %0d: got %0h expected %0h", name, what, row, got, exp);
    end
  endtask

  task automatic add_rows(input int n, input logic [WIDTH-1:0] act,
                          input logic rdy = 1'b1);
    vec_t v;
    v.act = act; v.rdy = rdy; v.clr = 1'b0;
    v.vld = 1'b0; v.btn = '0; v.code = '0; v.ovf = 1'b0;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic set_evt(input int r, input int b, input logic [1:0] c);
    vecs[r].vld  = 1'b1;
    vecs[r].btn  = IDX_W'(b);
    vecs[r].code = c;
  endtask

  task automatic run_table(input string name);
    for (int r = 0; r < vecs.size(); r++) begin
      btn_in    = ~vecs[r].act;
      evt_ready = vecs[r].rdy;
      clr_ovf   = vecs[r].clr;
      @(posedge clk);
      @(negedge clk);
      check(name, "valid", r, {7'd0, evt_valid}, {7'd0, vecs[r].vld});
      if (vecs[r].vld)
        check(name, "event", r, {3'd0, evt_btn, evt_code}, {3'd0, vecs[r].btn, vecs[r].code});
      check(name, "ovf", r, {7'd0, ovf}, {7'd0, vecs[r].ovf});
      check(name, "btn_active", r, {2'd0, btn_active}, {2'd0, vecs[r].act});
      $display("%s row %0d: valid=%0b btn=%0d code=%0d ovf=%0b", name, r,
               evt_valid, evt_btn, evt_code, ovf);
    end
    vecs.delete();
    clr_ovf = 1'b0;
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] act);
    reset_n   = 1'b0;
    btn_in    = ~act;
    evt_ready = 1'b1;
    clr_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    btn_in    = '1;
    evt_ready = 1'b1;
    clr_ovf   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", "valid", 0, {7'd0, evt_valid}, 8'd0);
    check("reset", "event", 0, {3'd0, evt_btn, evt_code}, 8'd0);
    check("reset", "ovf", 0, {7'd0, ovf}, 8'd0);
    reset_n = 1'b1;

    // Long hold of btn 2: PRESS, LONG after 8, REPEAT every 4, RELEASE
    do_reset('0);
    add_rows(30, 6'b000100);
    add_rows(6, 6'b000000);
    set_evt(2, 2, C_PRESS);
    set_evt(10, 2, C_LONG);
    for (int r = 14; r <= 30; r += 4) set_evt(r, 2, C_REPEAT);
    set_evt(32, 2, C_RELEASE);
    run_table("hold_btn2");

    // Short press of btn 4: no LONG
    do_reset('0);
    add_rows(5, 6'b010000);
    add_rows(8, 6'b000000);
    set_evt(2, 4, C_PRESS);
    set_evt(7, 4, C_RELEASE);
    run_table("short_btn4");

    // Simultaneous presses and round-robin order, including wrap of rr
    do_reset('0);
    add_rows(6, 6'b100011);
    add_rows(6, 6'b000000);
    add_rows(6, 6'b100001);
    add_rows(6, 6'b000000);
    add_rows(4, 6'b000010);
    add_rows(6, 6'b100011);
    set_evt(2, 0, C_PRESS);    set_evt(3, 1, C_PRESS);    set_evt(4, 5, C_PRESS);
    set_evt(8, 0, C_RELEASE);  set_evt(9, 1, C_RELEASE);  set_evt(10, 5, C_RELEASE);
    set_evt(14, 0, C_PRESS);   set_evt(15, 5, C_PRESS);
    set_evt(20, 0, C_RELEASE); set_evt(21, 5, C_RELEASE);
    set_evt(26, 1, C_PRESS);
    set_evt(30, 5, C_PRESS);   set_evt(31, 0, C_PRESS);
    run_table("round_robin");

    // Back-pressure on btn 3: stable output, drop sets ovf, clear, set-wins
    do_reset('0);
    add_rows(20, 6'b001000, 1'b0);
    add_rows(7, 6'b001000, 1'b1);
    add_rows(9, 6'b001000, 1'b0);
    vecs[24].clr = 1'b1;
    vecs[33].clr = 1'b1;
    for (int r = 2; r <= 19; r++) set_evt(r, 3, C_PRESS);
    set_evt(20, 3, C_LONG);
    set_evt(22, 3, C_REPEAT);
    for (int r = 26; r <= 35; r++) set_evt(r, 3, C_REPEAT);
    for (int r = 13; r <= 23; r++) vecs[r].ovf = 1'b1;
    for (int r = 33; r <= 35; r++) vecs[r].ovf = 1'b1;
    run_table("backpressure");

    // Release of btn 1 on the LONG threshold cycle
    do_reset('0);
    add_rows(8, 6'b000010);
    add_rows(9, 6'b000000);
    set_evt(2, 1, C_PRESS);
    set_evt(10, 1, C_RELEASE);
    run_table("long_edge");

    // Asynchronous reset in the middle of a hold
    do_reset('0);
    add_rows(11, 6'b001000);
    set_evt(2, 3, C_PRESS);
    set_evt(10, 3, C_LONG);
    run_table("pre_reset");
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", "valid", 0, {7'd0, evt_valid}, 8'd0);
    check("async_reset", "event", 0, {3'd0, evt_btn, evt_code}, 8'd0);
    check("async_reset", "ovf", 0, {7'd0, ovf}, 8'd0);
    $display("async_reset: valid=%0b btn=%0d code=%0d", evt_valid, evt_btn, evt_code);

    do_reset('0);
    add_rows(12, 6'b000000);
    run_table("reset_idle");

    do_reset(6'b000001);
    add_rows(8, 6'b000001);
    set_evt(2, 0, C_PRESS);
    run_table("reset_held");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
